// File: rtl/vram_arb.sv
// -----------------------------------------------------------------------------
// vram_arb -- single-port VRAM arbiter shared by a CPU and a video fetch unit.
//
// One RAM access may be granted per clock. Video wins while VBL=0, CPU wins
// while VBL=1. A bounded video burst keeps a waiting CPU from starving. The
// RAM is synchronous-read. A grant at edge k drives RAM_A/RAM_D/RAM_WE during
// the following cycle, and the RAM data is returned one cycle after that.
//
// Ports
//   CLK, RES            clock, synchronous active-high reset
//   VBL                 vertical blank (1 = CPU priority, 0 = video priority)
//   CPU_CS              CPU address decodes to VRAM
//   CPU_RDB, CPU_WRB    CPU read/write strobes, active-low
//   CPU_A, CPU_DI       CPU address / write data
//   CPU_DO              CPU read data, held until the next read completes
//   WAITB               CPU wait, active-low (combinational)
//   VID_REQ, VID_A      video fetch request (level) and address
//   VID_ACK             one-cycle pulse: video address issued to RAM
//   VID_VALID, VID_DO   one-cycle pulse with the fetched video byte
//   RAM_A, RAM_D        registered RAM address / write data
//   RAM_WE              registered RAM write enable, active-high
//   RAM_Q               RAM read data, one cycle after RAM_A
// -----------------------------------------------------------------------------
module vram_arb #(
  parameter int AW            = 10,
  parameter int MAX_VID_BURST = 4
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          VBL,
  input  logic          CPU_CS,
  input  logic          CPU_RDB,
  input  logic          CPU_WRB,
  input  logic [AW-1:0] CPU_A,
  input  logic [7:0]    CPU_DI,
  output logic [7:0]    CPU_DO,
  output logic          WAITB,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_A,
  output logic          VID_ACK,
  output logic          VID_VALID,
  output logic [7:0]    VID_DO,
  output logic [AW-1:0] RAM_A,
  output logic [7:0]    RAM_D,
  output logic          RAM_WE,
  input  logic [7:0]    RAM_Q
);

  localparam int CW = (MAX_VID_BURST < 2) ? 1 : $clog2(MAX_VID_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_VID_BURST);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_VID
  } gnt_e;

  gnt_e          gnt;
  logic          strobe, cpu_sel, cpu_wr, cpu_pend, cpu_req;
  logic          cpu_done;
  logic          p1_cpu, p1_rd, p2_cpu, p2_rd;  // CPU access pipeline stages
  logic [CW-1:0] burst_cnt;
  logic [AW-1:0] ram_a_q;
  logic [7:0]    ram_d_q, cpu_do_q;
  logic          ram_we_q, vid_ack_q, vid_valid_q;

  assign strobe   = ~CPU_RDB | ~CPU_WRB;
  assign cpu_sel  = CPU_CS & strobe;
  assign cpu_wr   = ~CPU_WRB;              // both strobes low counts as a write
  assign cpu_pend = cpu_sel & ~cpu_done;
  // cpu_done only rises at completion, so an access already in the pipeline
  // must be masked here or the same strobe would be granted again.
  assign cpu_req  = cpu_pend & ~p1_cpu & ~p2_cpu;

  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = GNT_NONE;
    if (cpu_req && VID_REQ) begin
      gnt = (VBL || burst_cnt == BURST_MAX) ? GNT_CPU : GNT_VID;
    end else if (cpu_req) begin
      gnt = GNT_CPU;
    end else if (VID_REQ) begin
      gnt = GNT_VID;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RES) begin
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      ram_we_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_do_q    <= '0;
      cpu_done    <= 1'b0;
      p1_cpu      <= 1'b0;
      p1_rd       <= 1'b0;
      p2_cpu      <= 1'b0;
      p2_rd       <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      ram_we_q  <= 1'b0;
      vid_ack_q <= 1'b0;
      unique case (gnt)
        GNT_CPU: begin
          ram_a_q  <= CPU_A;
          ram_we_q <= cpu_wr;
          if (cpu_wr) ram_d_q <= CPU_DI;
        end
        GNT_VID: begin
          ram_a_q   <= VID_A;
          vid_ack_q <= 1'b1;
        end
        default: ;  // idle: RAM_A and RAM_D hold
      endcase

      p1_cpu      <= (gnt == GNT_CPU);
      p1_rd       <= (gnt == GNT_CPU) && !cpu_wr;
      p2_cpu      <= p1_cpu;
      p2_rd       <= p1_rd;
      vid_valid_q <= vid_ack_q;

      if (p2_rd) cpu_do_q <= RAM_Q;

      // An abandoned strobe still finishes its RAM access but must not leave
      // cpu_done set, or the next strobe would be swallowed.
      if (p2_cpu && cpu_sel) begin
        cpu_done <= 1'b1;
      end else if (CPU_RDB && CPU_WRB) begin
        cpu_done <= 1'b0;
      end

      if (gnt == GNT_CPU || !cpu_req) begin
        burst_cnt <= '0;
      end else if (gnt == GNT_VID && burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign RAM_A     = ram_a_q;
  assign RAM_D     = ram_d_q;
  // Gating with RES cancels a write whose enable cycle overlaps reset.
  assign RAM_WE    = ram_we_q & ~RES;
  assign VID_ACK   = vid_ack_q;
  assign VID_VALID = vid_valid_q;
  // RAM_Q is valid in the VID_VALID cycle, so it is passed straight through.
  assign VID_DO    = vid_valid_q ? RAM_Q : 8'h00;
  assign CPU_DO    = cpu_do_q;
  assign WAITB     = RES | ~cpu_pend;

endmodule

// File: tb/tb_vram_arb.sv
// -----------------------------------------------------------------------------
// tb_vram_arb -- self-checking bench for vram_arb.
// A synchronous-read RAM model sits on the RAM port. CPU accesses come from a
// table of {op, address, data, expected CPU_DO, expected wait cycles}. Video
// fetches are queued addresses; the expected byte is pushed to a scoreboard
// when VID_ACK is seen and popped when VID_VALID arrives.
// -----------------------------------------------------------------------------
module tb_vram_arb;

  logic       clk = 1'b0;
  logic       res, vbl, cpu_cs, cpu_rdb, cpu_wrb;
  logic [9:0] cpu_a, vid_a, ram_a;
  logic [7:0] cpu_di, cpu_do, vid_do, ram_d, ram_q;
  logic       waitb, vid_req, vid_ack, vid_valid, ram_we;

  vram_arb #(.AW(10), .MAX_VID_BURST(4)) dut (
    .CLK(clk), .RES(res), .VBL(vbl),
    .CPU_CS(cpu_cs), .CPU_RDB(cpu_rdb), .CPU_WRB(cpu_wrb),
    .CPU_A(cpu_a), .CPU_DI(cpu_di), .CPU_DO(cpu_do), .WAITB(waitb),
    .VID_REQ(vid_req), .VID_A(vid_a), .VID_ACK(vid_ack),
    .VID_VALID(vid_valid), .VID_DO(vid_do),
    .RAM_A(ram_a), .RAM_D(ram_d), .RAM_WE(ram_we), .RAM_Q(ram_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- RAM model (preloaded with the low address byte) ----------
  logic [7:0] mem [1024];
  logic       loaded = 1'b0;
  int         ram_wr_cnt = 0;
  logic [9:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
      loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_a] <= ram_d;
      ram_wr_cnt <= ram_wr_cnt + 1;
      last_wa    <= ram_a;
      last_wd    <= ram_d;
    end
    ram_q <= mem[ram_a];
  end

  // ---------------- reference memory, video queue, scoreboard ----------------
  logic [7:0] ref_mem [1024];
  logic [9:0] vid_q [$];
  logic [7:0] exp_q [$];
  int         vv_run = 0, vv_max = 0;
  logic       w_en = 1'b0, w_gap = 1'b0, w_done = 1'b0, w_resume = 1'b0;
  int         w_acks = 0;

  task automatic watch_start();
    w_acks = 0; w_gap = 1'b0; w_done = 1'b0; w_resume = 1'b0; w_en = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_v;
    vid_req = 1'b0;
    vid_a   = '0;
    forever begin
      @(posedge clk); #2;
      if (vid_valid) begin
        if (exp_q.size() == 0) check("vid_valid_without_expect", vid_valid, 1'b0);
        else begin
          exp_v = exp_q.pop_front();
          check("vid_do", vid_do, exp_v);
        end
        vv_run++;
      end else begin
        vv_run = 0;
      end
      if (vv_run > vv_max) vv_max = vv_run;
      if (vid_ack) begin
        if (vid_q.size() == 0) check("vid_ack_without_request", vid_ack, 1'b0);
        else begin
          exp_q.push_back(ref_mem[vid_q[0]]);
          void'(vid_q.pop_front());
        end
      end
      if (w_en) begin
        if (!w_gap) begin
          if (vid_ack) w_acks++;
          else w_gap = 1'b1;
        end else if (!w_done) begin
          w_resume = vid_ack;
          w_done   = 1'b1;
        end
      end
      vid_req = (vid_q.size() != 0);
      vid_a   = vid_req ? vid_q[0] : '0;
      @(negedge clk); #1;
      vid_req = (vid_q.size() != 0);
      vid_a   = vid_req ? vid_q[0] : '0;
    end
  end

  // Caller is at a negedge; strobe is asserted immediately.
  task automatic cpu_access(input logic wr, input logic [9:0] a, input logic [7:0] d,
                            output logic [7:0] q, output int waits);
    cpu_cs = 1'b1; cpu_a = a; cpu_di = d;
    if (wr) cpu_wrb = 1'b0; else cpu_rdb = 1'b0;
    #1 check("waitb_low_on_strobe", waitb, 1'b0);
    waits = 0;
    while (waits < 60) begin
      @(negedge clk);
      if (waitb) break;
      waits++;
    end
    if (waits >= 60) check("cpu_wait_timeout", waitb, 1'b1);
    q = cpu_do;
    if (wr) ref_mem[a] = d;
    cpu_cs = 1'b0; cpu_rdb = 1'b1; cpu_wrb = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((vid_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < 200), 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [9:0] a;
    logic [7:0] d;
    logic [7:0] exp_do;
    int         exp_wait;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    int         waits, wc;

    vecs[0] = '{1'b1, 10'h155, 8'hA5, 8'h00, 2};
    vecs[1] = '{1'b0, 10'h155, 8'h00, 8'hA5, 2};
    vecs[2] = '{1'b1, 10'h200, 8'h3C, 8'hA5, 2};
    vecs[3] = '{1'b0, 10'h200, 8'h00, 8'h3C, 2};
    vecs[4] = '{1'b0, 10'h2AA, 8'h00, 8'hAA, 2};
    vecs[5] = '{1'b1, 10'h3FF, 8'h5A, 8'hAA, 2};
    vecs[6] = '{1'b0, 10'h3FF, 8'h00, 8'h5A, 2};
    vecs[7] = '{1'b0, 10'h010, 8'h00, 8'h10, 2};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);

    // Reset with both requesters active: nothing granted, WAITB held high.
    res = 1'b1; vbl = 1'b0;
    cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_wrb = 1'b1; cpu_a = 10'h155; cpu_di = 8'hFF;
    vid_q.push_back(10'h007);
    repeat (3) @(negedge clk);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_vid_ack", vid_ack, 1'b0);
    check("rst_vid_valid", vid_valid, 1'b0);
    check("rst_ram_a", ram_a, 10'h000);
    check("rst_ram_d", ram_d, 8'h00);
    check("rst_cpu_do", cpu_do, 8'h00);
    check("rst_vid_do", vid_do, 8'h00);
    check("rst_waitb", waitb, 1'b1);
    res = 1'b0; cpu_cs = 1'b0; cpu_rdb = 1'b1;
    watch_start();
    drain("first_grant");
    check("first_grant_after_reset_acks", w_acks, 1);
    w_en = 1'b0;

    // Table-driven CPU accesses with video idle.
    for (int i = 0; i < 8; i++) begin
      wc = ram_wr_cnt;
      @(negedge clk);
      cpu_access(vecs[i].wr, vecs[i].a, vecs[i].d, q, waits);
      check($sformatf("vec%0d_cpu_do", i), q, vecs[i].exp_do);
      check($sformatf("vec%0d_wait_cycles", i), waits, vecs[i].exp_wait);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_ram_writes", i), ram_wr_cnt, wc + 1);
        check($sformatf("vec%0d_ram_a", i), last_wa, vecs[i].a);
        check($sformatf("vec%0d_ram_d", i), last_wd, vecs[i].d);
      end else begin
        check($sformatf("vec%0d_no_ram_write", i), ram_wr_cnt, wc);
      end
    end

    // 8 back-to-back video fetches from 0x000..0x007.
    vv_max = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) vid_q.push_back(10'(i));
    drain("vid_burst8");
    check("vid_valid_back_to_back", vv_max, 8);

    // VBL=0: video streaming, CPU read waits out a burst of 4.
    vbl = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) vid_q.push_back(10'h020 + 10'(i));
    repeat (2) @(negedge clk);
    watch_start();
    cpu_access(1'b0, 10'h155, 8'h00, q, waits);
    check("burst_cpu_do", q, 8'hA5);
    check("burst_cpu_wait", waits, 6);
    check("burst_vid_acks_before_cpu", w_acks, 4);
    check("burst_vid_resumes", w_resume, 1'b1);
    drain("burst");
    w_en = 1'b0;

    // VBL=1: simultaneous requests, CPU first, video one cycle later.
    vbl = 1'b1;
    @(negedge clk);
    vid_q.push_back(10'h033);
    watch_start();
    cpu_access(1'b0, 10'h155, 8'h00, q, waits);
    check("vbl_cpu_do", q, 8'hA5);
    check("vbl_cpu_wait", waits, 2);
    check("vbl_vid_acks_before_cpu", w_acks, 0);
    check("vbl_vid_follows", w_resume, 1'b1);
    drain("vbl");
    w_en = 1'b0;
    vbl = 1'b0;

    // Reset lands in the RAM_WE cycle of a CPU write: write is cancelled.
    wc = ram_wr_cnt;
    @(negedge clk);
    cpu_cs = 1'b1; cpu_wrb = 1'b0; cpu_a = 10'h0F0; cpu_di = 8'h77;
    @(negedge clk);
    check("pre_reset_ram_we", ram_we, 1'b1);
    res = 1'b1;
    #1;
    check("reset_gates_ram_we", ram_we, 1'b0);
    check("reset_forces_waitb", waitb, 1'b1);
    @(negedge clk);
    check("post_reset_ram_we", ram_we, 1'b0);
    check("post_reset_ram_a", ram_a, 10'h000);
    check("post_reset_ram_d", ram_d, 8'h00);
    check("post_reset_cpu_do", cpu_do, 8'h00);
    check("post_reset_vid_ack", vid_ack, 1'b0);
    check("post_reset_waitb", waitb, 1'b1);
    check("cancelled_write_count", ram_wr_cnt, wc);
    cpu_cs = 1'b0; cpu_wrb = 1'b1; res = 1'b0;
    @(negedge clk);
    cpu_access(1'b0, 10'h0F0, 8'h00, q, waits);
    check("cancelled_write_readback", q, 8'hF0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter AW, 10, VRAM address width (1 KiB VRAM).
REQ-002 Parameter MAX_VID_BURST, 4, maximum consecutive video grants while a CPU access is pending.
REQ-003 CLK  in  1  system clock; all state changes on posedge CLK.
REQ-004 RES  in  1  synchronous reset, active-high.
REQ-005 VBL  in  1  vertical blank; 1 = CPU priority, 0 = video priority.
REQ-006 CPU_CS  in  1  CPU address decodes to VRAM, active-high.
REQ-007 CPU_RDB / CPU_WRB  in  1 each  CPU read/write strobes, active-low.
REQ-008 CPU_A  in  AW  CPU address.
REQ-009 CPU_DI  in  8  CPU write data.
REQ-010 CPU_DO  out  8  CPU read data, held from completion until next CPU read completes.
REQ-011 WAITB  out  1  CPU wait, active-low.
REQ-012 VID_REQ  in  1  video fetch request, level; VID_A held stable until VID_ACK.
REQ-013 VID_A  in  AW  video fetch address.
REQ-014 VID_ACK  out  1  one-cycle pulse: video address issued to RAM.
REQ-015 VID_VALID  out  1  one-cycle pulse: VID_DO valid.
REQ-016 VID_DO  out  8  video read data.
REQ-017 RAM_A  out  AW  registered RAM address.
REQ-018 RAM_D  out  8  registered RAM write data.
REQ-019 RAM_WE  out  1  registered write enable, active-high.
REQ-020 RAM_Q  in  8  RAM read data, valid one cycle after RAM_A (synchronous-read RAM).

Function
REQ-021 cpu_pend = CPU_CS & (~CPU_RDB | ~CPU_WRB) & ~cpu_done; one RAM access per CPU strobe assertion.
REQ-022 Arbitration on each posedge where no grant issued in prior cycle is needed: at most one grant per cycle; pipeline permits grants on consecutive cycles.
REQ-023 Grant rule: both pending and VBL=1 -> CPU; both pending and VBL=0 -> video, unless burst counter = MAX_VID_BURST -> CPU; single requester -> that requester; none -> idle (RAM_WE=0, RAM_A holds).
REQ-024 Burst counter increments on each video grant while cpu_pend=1; clears on CPU grant or when cpu_pend=0; saturates at MAX_VID_BURST.
REQ-025 Grant at edge k: RAM_A (and RAM_D/RAM_WE for writes) valid cycle k+1; RAM_Q captured at edge k+2.
REQ-026 Video grant at edge k: VID_ACK=1 in cycle k+1; VID_VALID=1 and VID_DO=RAM_Q in cycle k+2.
REQ-027 CPU write grant at edge k: RAM_WE=1 only in cycle k+1, RAM_D=CPU_DI, RAM_A=CPU_A; cpu_done set at edge k+2.
REQ-028 CPU read grant at edge k: RAM_WE=0; CPU_DO=RAM_Q and cpu_done set at edge k+2.
REQ-029 WAITB = 0 whenever CPU_CS & strobe active & ~cpu_done (combinational); 1 otherwise.
REQ-030 cpu_done clears on the edge where CPU_RDB & CPU_WRB both sample 1; no CPU grant while cpu_done=1.
REQ-031 CPU_RDB and CPU_WRB both low: treated as write.
REQ-032 CPU strobe removed after grant but before completion: access completes, RAM write still occurs, cpu_done not set.
REQ-033 VID_REQ held after VID_ACK requests a new fetch (new VID_A); earliest next video grant is the edge VID_ACK is high.
REQ-034 VBL change takes effect at next arbitration edge; in-flight accesses unaffected.

Reset
REQ-035 RES=1 at posedge: burst counter 0, cpu_done 0, pipeline emptied; RAM_WE, VID_ACK, VID_VALID 0; RAM_A, RAM_D, CPU_DO, VID_DO 0.
REQ-036 While RES=1: no grants, WAITB=1 regardless of CPU inputs; in-flight RAM writes during reset are cancelled.
REQ-037 First grant possible at first posedge with RES=0.

Verification
REQ-038 CPU write A=0x155 D=0xA5, VID_REQ=0 -> RAM_WE=1 one cycle with RAM_A=0x155, RAM_D=0xA5; WAITB returns 1 two cycles after grant.
REQ-039 CPU read A=0x155 after 0xA5 written -> CPU_DO=0xA5, WAITB low exactly 2 cycles after strobe sampled.
REQ-040 VBL=0, VID_REQ held, CPU read pending -> exactly 4 VID_ACK pulses, then CPU grant, then video resumes.
REQ-041 VBL=1, both pending -> CPU granted first; VID_ACK delayed one cycle.
REQ-042 VID_REQ held 8 cycles, addresses 0x000..0x007, RAM preloaded with address value -> 8 back-to-back VID_VALID with VID_DO=0x00..0x07.
REQ-043 RES asserted in the cycle RAM_WE would be 1 -> no write, WAITB=1, all outputs at reset values next cycle.
